// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared widths and the hard-wired zero register index
package regfile_sb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write-back and issue signals of the scoreboarded register file
interface regfile_sb_if #(
  parameter int DATA_W = regfile_sb_pkg::DATA_W,
  parameter int ADDR_W = regfile_sb_pkg::ADDR_W
);
  logic [ADDR_W-1:0] RsAddr, RtAddr, WbAddr, IssueAddr;
  logic [DATA_W-1:0] RsData, RtData, WbData;
  logic WbEna, IssueEna, Stall;
  logic [2**ADDR_W-1:0] BusyMask;
  modport master (
    output RsAddr, RtAddr, WbEna, WbAddr, WbData, IssueEna, IssueAddr,
    input  RsData, RtData, Stall, BusyMask
  );
  modport slave (
    input  RsAddr, RtAddr, WbEna, WbAddr, WbData, IssueEna, IssueAddr,
    output RsData, RtData, Stall, BusyMask
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits (issue sets, write-back clears, set wins) and operand Stall
module regfile_scoreboard #(
  parameter int ADDR_W = regfile_sb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rsAddr,
  input  logic [ADDR_W-1:0] rtAddr,
  input  logic              wbEna,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic              issueEna,
  input  logic [ADDR_W-1:0] issueAddr,
  input  logic              fwdA,
  input  logic              fwdB,
  input  logic              rawHaz,
  output logic              stall,
  output logic [2**ADDR_W-1:0] busyMask
);
  import regfile_sb_pkg::*;
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [NREGS-1:0] busy, setVec, clrVec;
  // one-hot set/clear requests; register 0 can never be marked busy
  always_comb begin
    setVec = (issueEna && issueAddr != ZERO) ? NREGS'(1) << issueAddr : '0;
    clrVec = (wbEna && wbAddr != ZERO) ? NREGS'(1) << wbAddr : '0;
  end
  // busy vector: a same-cycle issue re-arms a bit that write-back is clearing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= setVec | (busy & ~clrVec);
  // operand hazard unless the value is being forwarded this cycle
  always_comb begin
    stall = (rsAddr != ZERO && busy[rsAddr] && !fwdA) ||
            (rtAddr != ZERO && busy[rtAddr] && !fwdB) || rawHaz;
  end
  assign busyMask = busy;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with r0 hard-wired to zero and a pending-write scoreboard;
// define REGFILE_BYPASS_EN to forward same-cycle write-back data to readers instead of stalling them
module regfile_sb #(
  parameter int DATA_W = regfile_sb_pkg::DATA_W,
  parameter int ADDR_W = regfile_sb_pkg::ADDR_W
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  import regfile_sb_pkg::*;
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [DATA_W-1:0] regs [NREGS];
  logic wbLive, hitA, hitB, fwdA, fwdB, rawHaz;
  assign wbLive = bus.WbEna && bus.WbAddr != ZERO;
  assign hitA = wbLive && bus.RsAddr == bus.WbAddr;
  assign hitB = wbLive && bus.RtAddr == bus.WbAddr;
`ifdef REGFILE_BYPASS_EN
  assign fwdA = hitA;
  assign fwdB = hitB;
  assign rawHaz = 1'b0;
`else
  assign fwdA = 1'b0;
  assign fwdB = 1'b0;
  assign rawHaz = hitA || hitB;
`endif
  // storage: write-back to any register but r0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wbLive) regs[bus.WbAddr] <= bus.WbData;
  // combinational read ports, r0 reads zero, forwarded data takes precedence
  always_comb begin
    bus.RsData = (bus.RsAddr == ZERO) ? '0 : fwdA ? bus.WbData : regs[bus.RsAddr];
    bus.RtData = (bus.RtAddr == ZERO) ? '0 : fwdB ? bus.WbData : regs[bus.RtAddr];
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W)) scoreboard (
    .clk(clk),
    .rst_n(rst_n),
    .rsAddr(bus.RsAddr),
    .rtAddr(bus.RtAddr),
    .wbEna(bus.WbEna),
    .wbAddr(bus.WbAddr),
    .issueEna(bus.IssueEna),
    .issueAddr(bus.IssueAddr),
    .fwdA(fwdA),
    .fwdB(fwdB),
    .rawHaz(rawHaz),
    .stall(bus.Stall),
    .busyMask(bus.BusyMask)
  );
endmodule
